// File: rtl/sdram_read_capture_pkg.sv
// Shared constants and FSM encoding for the SDRAM read capture stage.
package sdram_read_capture_pkg;

   localparam int SDR_DATA_W        = 16;   // SDRAM DQ width
   localparam int SDR_FIFO_AW       = 9;    // 512-word capture FIFO
   localparam int SDR_VLD_DELAY     = 2;    // CAS latency alignment
   localparam int SDR_SESSION_WORDS = 256;  // 64 bursts x 4 beats
   localparam int BURST_LEN         = 4;

   // One-hot session FSM
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_TRIG  = 5'b00010,
      S_START = 5'b00100,
      S_RUN   = 5'b01000,
      S_DRAIN = 5'b10000
   } cap_state_t;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module sdram_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int AW     = 9
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   localparam int DEPTH = 2**AW;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_nxt;
   logic [AW:0]       level_nxt;
   logic              push_ok;
   logic              pop_ok;

   assign full       = (level == (AW+1)'(DEPTH));
   assign empty      = (level == '0);
   assign pop_ok     = pop & ~empty;
   assign push_ok    = push & (~full | pop_ok);
   assign rd_ptr_nxt = rd_ptr + AW'(pop_ok);
   assign level_nxt  = level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers, level and head register; the head bypasses din when the
   // word being written is the one that becomes the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr_nxt;
         level  <= level_nxt;
         valid  <= (level_nxt != '0);
         if (level_nxt != '0)
            dout <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/sdram_read_capture.sv
// SDRAM read capture: aligns the engine beat strobe to CAS latency, stores
// beats in a FIFO, streams them out, and requests sessions only when the
// FIFO can absorb a whole session.
module sdram_read_capture
   import sdram_read_capture_pkg::*;
#(
   parameter int DATA_W        = SDR_DATA_W,
   parameter int FIFO_AW       = SDR_FIFO_AW,
   parameter int VLD_DELAY     = SDR_VLD_DELAY,
   parameter int SESSION_WORDS = SDR_SESSION_WORDS
)(
   input  logic               sysclk_100M,
   input  logic               rst,
   input  logic [DATA_W-1:0]  sdram_dq_in,
   input  logic               data_vld,
   input  logic               arbit_read_end,
   output logic               read_trig,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow
);

   localparam int SPACE_MAX = (1 << FIFO_AW) - SESSION_WORDS;

   cap_state_t  state;
   logic [2:0]  drain_cnt;
   logic [9:0]  inflight;
   logic        beat_wr;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic        space_ok;

   generate
      if (VLD_DELAY == 0) begin : g_nodly
         assign beat_wr = data_vld;
      end else begin : g_dly
         logic [VLD_DELAY:1] vld_pipe;
         // Strobe delay line matching the DQ beat to its data_vld
         always_ff @(posedge sysclk_100M) begin
            if (rst) vld_pipe <= '0;
            else begin
               vld_pipe[1] <= data_vld;
               for (int i = 2; i <= VLD_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
         end
         assign beat_wr = vld_pipe[VLD_DELAY];
      end
   endgenerate

   assign fifo_pop = rd_ready & ~fifo_empty;
   // Stored words plus words still owed by a granted session must leave a session of room
   assign space_ok = (({1'b0, fifo_level} + {1'b0, inflight}) <= 11'(SPACE_MAX));

   sdram_sync_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo (
      .clk   (sysclk_100M),
      .rst   (rst),
      .push  (beat_wr),
      .din   (sdram_dq_in),
      .pop   (fifo_pop),
      .dout  (rd_data),
      .valid (rd_valid),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Session FSM with registered one-cycle read_trig
   always_ff @(posedge sysclk_100M) begin
      if (rst) begin
         state     <= S_IDLE;
         read_trig <= 1'b0;
         drain_cnt <= '0;
      end else begin
         read_trig <= 1'b0;
         case (state)
            S_IDLE:  if (arbit_read_end && space_ok) begin
                        state     <= S_TRIG;
                        read_trig <= 1'b1;
                     end
            S_TRIG:  state <= S_START;
            S_START: if (!arbit_read_end) state <= S_RUN;
            S_RUN:   if (arbit_read_end) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 3'(VLD_DELAY);
                     end
            S_DRAIN: if (drain_cnt == '0) state <= S_IDLE;
                     else                 drain_cnt <= drain_cnt - 3'd1;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Words still expected from the granted session
   always_ff @(posedge sysclk_100M) begin
      if (rst)                           inflight <= '0;
      else if (state == S_TRIG)          inflight <= 10'(SESSION_WORDS);
      else if (beat_wr && inflight != 0) inflight <= inflight - 10'd1;
   end

   // Sticky flag for a beat dropped at a full FIFO
   always_ff @(posedge sysclk_100M) begin
      if (rst)                                 overflow <= 1'b0;
      else if (beat_wr && fifo_full && !fifo_pop) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_sdram_read_capture.sv
// Randomized bench for sdram_read_capture: engine model, queue scoreboard,
// negedge monitor comparing the output stream, level and overflow.
module tb_sdram_read_capture;
   import sdram_read_capture_pkg::*;

   localparam int VD    = 2;
   localparam int SW    = 256;
   localparam int DEPTH = 512;

   logic        sysclk_100M = 1'b0;
   logic        rst;
   logic [15:0] sdram_dq_in;
   logic        data_vld;
   logic        arbit_read_end;
   logic        read_trig;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [9:0]  fifo_level;
   logic        overflow;

   always #5 sysclk_100M = ~sysclk_100M;

   sdram_read_capture #(.DATA_W(16), .FIFO_AW(9), .VLD_DELAY(VD), .SESSION_WORDS(SW)) dut (
      .sysclk_100M    (sysclk_100M),
      .rst            (rst),
      .sdram_dq_in    (sdram_dq_in),
      .data_vld       (data_vld),
      .arbit_read_end (arbit_read_end),
      .read_trig      (read_trig),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .fifo_level     (fifo_level),
      .overflow       (overflow)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: words that must come out, in order
   logic [15:0] exp_q[$];
   int          outstanding;
   bit          exp_ovf;
   int          popped;
   bit          beat_land;
   logic [15:0] beat_word;

   // Engine / driver state
   int          cyc, e_st, e_cnt, e_beats, bcnt;
   int          trig_cnt, sessions_done, ready_mode, data_mode;
   bit          eng_en, force_vld, prev_trig;
   bit          land_v[8];
   logic [15:0] land_w[8];
   logic [15:0] word_ctr;

   // Monitor: compare DUT state after each edge, then advance the model for the next edge
   always @(negedge sysclk_100M) begin
      int  sz;
      bit  pop;
      if (rst) begin
         exp_q.delete();
         exp_ovf     = 1'b0;
         outstanding = 0;
      end else begin
         sz = exp_q.size();
         chk("level", 32'(fifo_level), 32'(sz));
         chk("overflow", 32'(overflow), 32'(exp_ovf));
         chk("rd_valid", 32'(rd_valid), 32'(sz > 0));
         if (sz > 0 && rd_valid) chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
         pop = (sz > 0) && rd_ready;
         if (pop) begin
            void'(exp_q.pop_front());
            popped++;
         end
         if (beat_land) begin
            if (outstanding > 0) outstanding--;
            if (sz < DEPTH || pop) exp_q.push_back(beat_word);
            else                   exp_ovf = 1'b1;
         end
      end
   end

   // One clock of stimulus: engine model, CAS-delayed DQ, rd_ready
   task automatic step();
      bit v;
      int s;
      @(posedge sysclk_100M);
      #1;
      cyc++;
      if (read_trig) begin
         chk("trig_single", 32'(prev_trig), 0);
         chk("trig_engine_idle", 32'(arbit_read_end), 1);
         chk("trig_space", 32'((exp_q.size() + outstanding) <= (DEPTH - SW)), 1);
         trig_cnt++;
         outstanding += SW;
      end
      prev_trig = read_trig;
      v = 1'b0;
      if (!rst) begin
         v = force_vld;
         case (e_st)
            0: if (read_trig && eng_en) begin e_st = 1; e_cnt = $urandom_range(1, 3); end
            1: begin
                  e_cnt--;
                  if (e_cnt == 0) begin arbit_read_end = 1'b0; e_st = 2; e_beats = 0; bcnt = 0; end
               end
            2: begin
                  v = 1'b1; e_beats++; bcnt++;
                  if (e_beats == SW) begin e_st = 4; e_cnt = $urandom_range(1, 4); end
                  else if (bcnt == BURST_LEN) begin
                     bcnt  = 0;
                     e_cnt = $urandom_range(0, 2);
                     if (e_cnt > 0) e_st = 3;
                  end
               end
            3: begin e_cnt--; if (e_cnt == 0) e_st = 2; end
            4: begin
                  e_cnt--;
                  if (e_cnt == 0) begin arbit_read_end = 1'b1; e_st = 0; sessions_done++; end
               end
            default: e_st = 0;
         endcase
      end
      data_vld = v;
      if (v) begin
         s = (cyc + VD) % 8;
         land_v[s] = 1'b1;
         if (data_mode == 0) begin land_w[s] = word_ctr; word_ctr++; end
         else land_w[s] = 16'($urandom);
      end
      s = cyc % 8;
      beat_land = land_v[s] && !rst;
      beat_word = land_w[s];
      land_v[s] = 1'b0;
      sdram_dq_in = beat_land ? beat_word : 16'($urandom);
      case (ready_mode)
         0: rd_ready = 1'b1;
         1: rd_ready = 1'b0;
         2: rd_ready = 1'($urandom_range(0, 1));
         default: rd_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      e_st = 0; arbit_read_end = 1'b1; data_vld = 1'b0; force_vld = 1'b0;
      for (int i = 0; i < 8; i++) land_v[i] = 1'b0;
      repeat (n) step();
      chk("rst_read_trig", 32'(read_trig), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_overflow", 32'(overflow), 0);
      rst = 1'b0;
      trig_cnt = 0; sessions_done = 0; popped = 0; prev_trig = 1'b0;
   endtask

   initial begin
      rst = 1'b1; data_vld = 1'b0; arbit_read_end = 1'b1; rd_ready = 1'b1; sdram_dq_in = '0;
      cyc = 0; e_st = 0; e_cnt = 0; e_beats = 0; bcnt = 0; word_ctr = '0;
      eng_en = 1'b0; force_vld = 1'b0; ready_mode = 0; data_mode = 0;
      beat_land = 1'b0; beat_word = '0;
      for (int i = 0; i < 8; i++) begin land_v[i] = 1'b0; land_w[i] = '0; end

      // Reset release with an idle engine: exactly one trigger, one cycle after release
      do_reset(3);
      step();
      chk("t1_trig_latency", 32'(read_trig), 1);
      repeat (50) step();
      chk("t1_trig_once", 32'(trig_cnt), 1);

      // One session of incrementing words, drained at full rate
      eng_en = 1'b1; data_mode = 0; word_ctr = '0; ready_mode = 0;
      do_reset(2);
      for (int i = 0; i < 2000 && sessions_done < 1; i++) step();
      chk("t2_session_done", 32'(sessions_done), 1);
      eng_en = 1'b0;
      repeat (20) step();
      chk("t2_words_out", 32'(popped), 256);
      chk("t2_level_zero", 32'(fifo_level), 0);

      // No drain: two sessions fill the FIFO, then no further trigger
      eng_en = 1'b1; ready_mode = 1; data_mode = 1;
      do_reset(2);
      for (int i = 0; i < 4000 && sessions_done < 2; i++) step();
      chk("t3_two_sessions", 32'(sessions_done), 2);
      repeat (60) step();
      chk("t3_trig_count", 32'(trig_cnt), 2);
      chk("t3_level_full", 32'(fifo_level), 512);
      chk("t3_no_overflow", 32'(overflow), 0);

      // Forced beats at full: dropped, overflow set
      force_vld = 1'b1;
      repeat (3) step();
      force_vld = 1'b0;
      repeat (5) step();
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_level_full", 32'(fifo_level), 512);

      // Push and pop on the same edges at full
      for (int i = 0; i < 8; i++) begin
         force_vld  = (i < 6);
         ready_mode = (i >= 2) ? 0 : 1;
         step();
      end
      force_vld = 1'b0; ready_mode = 1;
      step();
      chk("t5_full_pushpop_level", 32'(fifo_level), 512);
      chk("t5_no_trig", 32'(trig_cnt), 2);

      // Drain: next trigger only once space allows
      ready_mode = 3;
      for (int i = 0; i < 3000 && trig_cnt < 3; i++) step();
      chk("t3_third_trig", 32'(trig_cnt >= 3), 1);
      ready_mode = 2;
      repeat (3000) step();

      // Reset in the middle of a session, then restart
      ready_mode = 0;
      for (int i = 0; i < 3000 && !(e_beats == 100 && (e_st == 2 || e_st == 3)); i++) step();
      chk("t6_reached_beat100", 32'(e_beats == 100 && (e_st == 2 || e_st == 3)), 1);
      do_reset(1);
      step();
      chk("t6_retrig", 32'(read_trig), 1);
      ready_mode = 3;
      repeat (1500) step();
      eng_en = 1'b0; ready_mode = 0;
      repeat (1000) step();
      chk("end_drained", 32'(fifo_level), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      miscompares++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
